// File: rtl/breakout_pkg.sv
// Shared breakout constants and game-state encoding. The datapath and renderer
// use these too, so changing a default here moves every block together.
package breakout_pkg;

  localparam int STATE_W         = 3;
  localparam int SCREEN_W_DEF    = 640;
  localparam int PADDLE_W_DEF    = 64;
  localparam int PADDLE_STEP_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_LOST     = 3'd3,
    ST_WIN      = 3'd4,
    ST_GAMEOVER = 3'd5
  } game_state_t;

  function automatic int center_pos(input int screen_w, input int paddle_w);
    return (screen_w - paddle_w) / 2;
  endfunction

endpackage

// File: rtl/breakout_paddle_ctrl.sv
// Paddle left-edge register with saturating left/right steps and a center load.
// Center load wins over any move requested in the same cycle.
module breakout_paddle_ctrl
  import breakout_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int PADDLE_W    = PADDLE_W_DEF,
  parameter int PADDLE_STEP = PADDLE_STEP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       center,
  input  logic       move_en,
  input  logic       left,
  input  logic       right,
  output logic [9:0] paddle_x
);

  localparam logic [10:0] X_MAX    = 11'(SCREEN_W - PADDLE_W);
  localparam logic [10:0] STEP     = 11'(PADDLE_STEP);
  localparam logic [9:0]  X_CENTER = 10'(center_pos(SCREEN_W, PADDLE_W));

  logic [10:0] x_ext;
  logic [10:0] x_dec;
  logic [10:0] x_inc;
  logic [10:0] x_next;
  logic        unused_msb;

  // 11-bit math keeps the subtract from wrapping below 0 and the add from wrapping past 1023
  always_comb begin
    x_ext = {1'b0, paddle_x};
    x_dec = (x_ext >= STEP) ? (x_ext - STEP) : 11'd0;
    x_inc = x_ext + STEP;
    if (x_inc > X_MAX) x_inc = X_MAX;

    x_next = x_ext;
    if (center)                         x_next = {1'b0, X_CENTER};
    else if (move_en && left && !right) x_next = x_dec;
    else if (move_en && right && !left) x_next = x_inc;
  end

  assign unused_msb = x_next[10];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) paddle_x <= X_CENTER;
    else       paddle_x <= x_next[9:0];
  end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: start edge detect, game FSM, lives, LOST delay and paddle.
// States: IDLE wait for start | SERVE ball parked | PLAY live | LOST respawn delay | WIN | GAMEOVER
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int PADDLE_W    = PADDLE_W_DEF,
  parameter int PADDLE_STEP = PADDLE_STEP_DEF,
  parameter int INIT_LIVES  = 3,
  parameter int LOST_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               left_db,
  input  logic               right_db,
  input  logic               start_db,
  input  logic               frame_tick,
  input  logic               ball_lost,
  input  logic               bricks_clear,
  output logic [STATE_W-1:0] state,
  output logic [9:0]         paddle_x,
  output logic [1:0]         lives,
  output logic               serve,
  output logic               play_en
);

  localparam int               CNT_W      = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LOST_FRAMES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(INIT_LIVES);

  game_state_t      state_r;
  game_state_t      state_n;
  logic [1:0]       lives_n;
  logic [CNT_W-1:0] lost_cnt;
  logic [CNT_W-1:0] lost_cnt_n;
  logic             start_q;
  logic             start_rise;
  logic             serve_n;
  logic             center_load;
  logic             move_en;

  // start_q resets high so a start button held through reset is not an edge
  assign start_rise = start_db & ~start_q;
  assign move_en    = frame_tick & ((state_r == ST_SERVE) | (state_r == ST_PLAY));
  assign state      = state_r;

  always_comb begin
    state_n     = state_r;
    lives_n     = lives;
    lost_cnt_n  = lost_cnt;
    serve_n     = 1'b0;
    center_load = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_rise) begin
          state_n     = ST_SERVE;
          lives_n     = LIVES_INIT;
          center_load = 1'b1;
        end
      end
      ST_SERVE: begin
        if (start_rise) begin
          state_n = ST_PLAY;
          serve_n = 1'b1;
        end
      end
      ST_PLAY: begin
        if (bricks_clear) begin
          state_n = ST_WIN;
        end else if (ball_lost) begin
          if (lives <= 2'd1) begin
            lives_n = 2'd0;
            state_n = ST_GAMEOVER;
          end else begin
            lives_n    = lives - 2'd1;
            state_n    = ST_LOST;
            lost_cnt_n = '0;
          end
        end
      end
      ST_LOST: begin
        if (frame_tick) begin
          if (lost_cnt == CNT_LAST) begin
            state_n     = ST_SERVE;
            center_load = 1'b1;
            lost_cnt_n  = '0;
          end else begin
            lost_cnt_n = lost_cnt + CNT_W'(1);
          end
        end
      end
      ST_WIN, ST_GAMEOVER: begin
        if (start_rise) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      lives    <= 2'd0;
      lost_cnt <= '0;
      start_q  <= 1'b1;
      serve    <= 1'b0;
      play_en  <= 1'b0;
    end else begin
      state_r  <= state_n;
      lives    <= lives_n;
      lost_cnt <= lost_cnt_n;
      start_q  <= start_db;
      serve    <= serve_n;
      play_en  <= (state_n == ST_PLAY);
    end
  end

  breakout_paddle_ctrl #(
    .SCREEN_W    (SCREEN_W),
    .PADDLE_W    (PADDLE_W),
    .PADDLE_STEP (PADDLE_STEP)
  ) u_paddle (
    .clk      (clk),
    .reset    (reset),
    .center   (center_load),
    .move_en  (move_en),
    .left     (left_db),
    .right    (right_db),
    .paddle_x (paddle_x)
  );

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: scripted vector table, corner sequences and a
// randomized run checked every cycle against a behavioural game model.
module tb_breakout_game_ctrl;

  localparam int SCREEN_W = 640, PADDLE_W = 64, STEP = 4, INIT_LIVES = 3, LOST_FRAMES = 60;
  localparam int X_MAX = SCREEN_W - PADDLE_W;
  localparam int X_CTR = X_MAX / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       left_db, right_db, start_db, frame_tick, ball_lost, bricks_clear;
  logic [2:0] state;
  logic [9:0] paddle_x;
  logic [1:0] lives;
  logic       serve, play_en;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: game phase 0..5 as named in the interface, plus counters
  int m_state, m_x, m_lives, m_serve, m_play_en, m_start_q, m_lost_ticks;

  typedef struct {
    bit l, r, s, ft, bl, bc;
    int e_state, e_x, e_lives, e_serve;
  } vec_t;
  vec_t tbl[11];

  breakout_game_ctrl dut (
    .clk(clk), .reset(reset), .left_db(left_db), .right_db(right_db),
    .start_db(start_db), .frame_tick(frame_tick), .ball_lost(ball_lost),
    .bricks_clear(bricks_clear), .state(state), .paddle_x(paddle_x),
    .lives(lives), .serve(serve), .play_en(play_en)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_x = X_CTR; m_lives = 0; m_serve = 0; m_play_en = 0;
    m_start_q = 1; m_lost_ticks = 0;
  endtask

  task automatic model_clk();
    bit rise;
    bit ctr;
    bit mv;
    int ns;
    rise = start_db && !m_start_q;
    ctr  = 0;
    mv   = frame_tick && (m_state == 1 || m_state == 2);
    ns   = m_state;
    m_serve = 0;
    case (m_state)
      0: if (rise) begin ns = 1; m_lives = INIT_LIVES; ctr = 1; end
      1: if (rise) begin ns = 2; m_serve = 1; end
      2: if (bricks_clear) ns = 4;
         else if (ball_lost) begin
           if (m_lives == 1) begin m_lives = 0; ns = 5; end
           else begin m_lives = m_lives - 1; ns = 3; m_lost_ticks = 0; end
         end
      3: if (frame_tick) begin
           m_lost_ticks++;
           if (m_lost_ticks == LOST_FRAMES) begin ns = 1; ctr = 1; end
         end
      default: if (rise) ns = 0;
    endcase
    if (ctr) m_x = X_CTR;
    else if (mv && left_db && !right_db) m_x = (m_x - STEP < 0) ? 0 : m_x - STEP;
    else if (mv && right_db && !left_db) m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
    m_state   = ns;
    m_play_en = (ns == 2);
    m_start_q = start_db;
  endtask

  task automatic step(input bit l, input bit r, input bit s, input bit ft, input bit bl, input bit bc);
    @(negedge clk);
    left_db = l; right_db = r; start_db = s; frame_tick = ft; ball_lost = bl; bricks_clear = bc;
    @(posedge clk);
    model_clk();
    #1;
    chk("state", int'(state), m_state);
    chk("paddle_x", int'(paddle_x), m_x);
    chk("lives", int'(lives), m_lives);
    chk("serve", int'(serve), m_serve);
    chk("play_en", int'(play_en), m_play_en);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"}, int'(state), 0);
    chk({tag, ".paddle_x"}, int'(paddle_x), X_CTR);
    chk({tag, ".lives"}, int'(lives), 0);
    chk({tag, ".serve"}, int'(serve), 0);
    chk({tag, ".play_en"}, int'(play_en), 0);
  endtask

  // asserted between edges so the outputs can only clear through the async path
  task automatic mid_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals(tag);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    bit cur_s;
    tbl[0]  = '{0,0,1,0,0,0, 0,288,0,0};
    tbl[1]  = '{0,0,0,0,0,0, 0,288,0,0};
    tbl[2]  = '{0,0,1,0,0,0, 1,288,3,0};
    tbl[3]  = '{0,1,1,1,0,0, 1,292,3,0};
    tbl[4]  = '{1,0,0,1,0,0, 1,288,3,0};
    tbl[5]  = '{1,1,0,1,0,0, 1,288,3,0};
    tbl[6]  = '{0,1,1,1,0,0, 2,292,3,1};
    tbl[7]  = '{0,0,1,0,0,0, 2,292,3,0};
    tbl[8]  = '{0,0,0,0,1,0, 3,292,2,0};
    tbl[9]  = '{0,0,1,0,0,0, 3,292,2,0};
    tbl[10] = '{0,1,0,1,0,0, 3,292,2,0};

    left_db = 0; right_db = 0; start_db = 1; frame_tick = 0; ball_lost = 0; bricks_clear = 0;
    reset = 1'b1;
    model_reset();
    #5;
    chk_reset_vals("por");
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].l, tbl[i].r, tbl[i].s, tbl[i].ft, tbl[i].bl, tbl[i].bc);
      chk($sformatf("vec%0d.state", i), int'(state), tbl[i].e_state);
      chk($sformatf("vec%0d.paddle_x", i), int'(paddle_x), tbl[i].e_x);
      chk($sformatf("vec%0d.lives", i), int'(lives), tbl[i].e_lives);
      chk($sformatf("vec%0d.serve", i), int'(serve), tbl[i].e_serve);
      chk($sformatf("vec%0d.play_en", i), int'(play_en), int'(tbl[i].e_state == 2));
    end

    // LOST already saw one tick; 58 more (with idle gaps) keep it there, the 60th re-serves centered
    for (int k = 2; k < LOST_FRAMES; k++) begin
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end
    chk("lost_hold.state", int'(state), 3);
    step(0, 1, 0, 1, 0, 0);
    chk("reserve.state", int'(state), 1);
    chk("reserve.paddle_x", int'(paddle_x), 288);

    for (int k = 1; k <= 80; k++) begin
      step(1, 0, 0, 1, 0, 0);
      if (k == 71) chk("left71.paddle_x", int'(paddle_x), 4);
      if (k == 72) chk("left72.paddle_x", int'(paddle_x), 0);
    end
    chk("left80.paddle_x", int'(paddle_x), 0);
    for (int k = 0; k < 10; k++) step(1, 1, 0, 1, 0, 0);
    chk("both.paddle_x", int'(paddle_x), 0);
    for (int k = 0; k < 200; k++) step(0, 1, 0, 1, 0, 0);
    chk("right200.paddle_x", int'(paddle_x), 576);

    step(0, 0, 1, 0, 0, 0);
    chk("play.state", int'(state), 2);
    chk("play.serve", int'(serve), 1);
    chk("play.play_en", int'(play_en), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("play2.serve", int'(serve), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("lost2.lives", int'(lives), 1);
    for (int k = 1; k <= LOST_FRAMES; k++) begin
      step(0, 0, 0, 1, 0, 0);
      if (k == LOST_FRAMES - 1) chk("lost59.state", int'(state), 3);
    end
    chk("lost60.state", int'(state), 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("gameover.state", int'(state), 5);
    chk("gameover.lives", int'(lives), 0);
    step(0, 0, 1, 0, 0, 0);
    chk("go_idle.state", int'(state), 0);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("newgame.lives", int'(lives), 3);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("win.state", int'(state), 4);
    chk("win.lives", int'(lives), 3);
    step(0, 0, 1, 0, 0, 0);
    chk("win_idle.state", int'(state), 0);
    chk("win_idle.lives", int'(lives), 3);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("pre_rst.play_en", int'(play_en), 1);
    mid_reset("midplay");

    cur_s = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) cur_s = ~cur_s;
      step(1'($urandom_range(1)), 1'($urandom_range(1)), cur_s,
           1'($urandom_range(3) == 0), 1'($urandom_range(15) == 0), 1'($urandom_range(59) == 0));
      if (n == 1500) mid_reset("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
